conv_enc_framer: RTL and testbench
==================================

Name: conv_enc_framer

Overview:
Upstream feeder for the rate-1/2, K=5 convolutional encoder core. Accepts bytes over a valid/ready handshake and serialises them MSB-first onto the encoder's bit/data_valid inputs. Keeps bit_valid continuously high for a whole frame, because the encoder clears its shift register whenever data_valid drops. Terminates every frame with K-1 zero tail bits so the trellis returns to state 0.

Parameters:
DATA_W, 8, input word width in bits (>=2)
TAIL_LEN, 4, number of zero flush bits per frame (= K-1; >=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
s_data  input  DATA_W  byte to serialise
s_valid  input  1  s_data valid
s_last  input  1  qualifies s_data as the final word of the frame
s_ready  output  1  framer accepts s_data this cycle
bit_out  output  1  serial bit to encoder d_in
bit_valid  output  1  to encoder data_valid; high for every data and tail bit
tail_active  output  1  current bit is a flush bit
frame_done  output  1  one-cycle pulse on the final tail bit
underrun  output  1  one-cycle pulse when a frame is force-terminated

Behaviour:
- Reset (async, any state): state=IDLE; shreg, bit_cnt, tail_cnt and last_flag all 0. bit_out, bit_valid, tail_active, frame_done and underrun are 0 immediately, without waiting for a clock edge.
- States: IDLE, SHIFT, TAIL.
- Outputs are pure decodes of registers:
  - bit_out = shreg[DATA_W-1] in SHIFT, 0 otherwise.
  - bit_valid = (state != IDLE).
  - tail_active = (state == TAIL).
- s_ready = (state==IDLE) OR (state==SHIFT AND bit_cnt==DATA_W-1 AND !last_flag). Combinational from registers only; never depends on s_valid.
- IDLE, on s_valid:
  - Load shreg=s_data, last_flag=s_last, bit_cnt=0; go to SHIFT.
  - The first bit appears on bit_out in the cycle after the accepting edge.
- SHIFT, each cycle: shreg<<=1, bit_cnt++.
- SHIFT, at bit_cnt==DATA_W-1:
  - last_flag=1: go to TAIL, tail_cnt=0.
  - last_flag=0 and s_valid=1: reload shreg/last_flag from the new word, bit_cnt=0, stay in SHIFT. No bubble; bit_valid stays high.
  - last_flag=0 and s_valid=0: underrun. Pulse underrun in the next cycle (registered), go to TAIL. The frame is terminated cleanly; data in flight is not lost, only the frame is shortened.
- TAIL:
  - bit_out=0, tail_cnt++.
  - At tail_cnt==TAIL_LEN-1: frame_done=1 (combinational, same cycle), then go to IDLE.
  - s_ready=0 throughout.
- Frame timing:
  - N words give exactly N*DATA_W+TAIL_LEN contiguous bit_valid cycles.
  - At least one IDLE cycle separates frames (bit_valid low), which also resets the encoder.
- s_valid held while s_ready=0: no effect; s_data/s_last must be held stable by the source.
- Counters: bit_cnt is clog2(DATA_W) wide; tail_cnt is clog2(TAIL_LEN+1) wide. No wrap beyond terminal counts.

Decomposition:
- Shared package conv_enc_pkg: state enum {IDLE,SHIFT,TAIL}; constants K=5, POLY_1=5'b10111, POLY_2=5'b11001, TAIL_LEN_DEF=K-1. The encoder and later decoder stages reuse these.
- No sub-module: a single FSM plus two counters and one shift register is not worth splitting.

Test Plan:
- Single word 0xA5 with s_last=1:
  - bit_out = 1,0,1,0,0,1,0,1 then 0,0,0,0 over 12 consecutive bit_valid cycles.
  - tail_active on cycles 9-12; frame_done on cycle 12; s_ready low cycles 1-12.
- Back-to-back 0x3C then 0xFF (last), with s_valid held high:
  - s_ready pulses exactly on bit 8.
  - 20 contiguous bit_valid cycles with bits 00111100 11111111 0000.
- Underrun: 0x81 with s_last=0, then s_valid=0:
  - bits 10000001 then 0000.
  - underrun pulses once (on the first tail cycle); frame_done on cycle 12.
- Reset mid-frame: assert rst during bit 3 of 0xF0.
  - bit_valid and bit_out drop in the same cycle; state=IDLE; s_ready=1 after release.
  - A new word 0x01 (last) then frames normally.
- Integrated with the encoder core (default polynomials), input 0x80 with s_last=1:
  - Encoder output pairs {cw1,cw0} = 11,01,10,10,11 on bits 1-5, then 00 for the remaining 7 bits.
  - Encoder output returns to 00 after frame_done.

Source files
------------

// File: rtl/conv_enc_pkg.sv
// Shared definitions for the K=5 rate-1/2 convolutional coding chain.
// Holds the framer state encoding and the code constants reused downstream.
package conv_enc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL
    } state_t;

    localparam int           K            = 5;
    localparam logic [K-1:0] POLY_1       = 5'b10111;
    localparam logic [K-1:0] POLY_2       = 5'b11001;
    localparam int           TAIL_LEN_DEF = K - 1;

endpackage

// File: rtl/conv_enc_framer.sv
// Byte-to-bit framer feeding the convolutional encoder core.
// Ports:
//   clk, rst (async, active high)
//   s_data/s_valid/s_last/s_ready : word input handshake
//   bit_out/bit_valid              : serial bit stream to the encoder
//   tail_active                    : current bit is a zero flush bit
//   frame_done                     : pulse on the final tail bit
//   underrun                       : pulse when a frame is cut short
module conv_enc_framer
    import conv_enc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TAIL_LEN = TAIL_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              tail_active,
    output logic              frame_done,
    output logic              underrun
);

    localparam int BW = $clog2(DATA_W);
    localparam int TW = $clog2(TAIL_LEN + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_LEN - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [TW-1:0]     tail_cnt;
    logic              last_flag;
    logic              underrun_q;
    logic              word_end;

    assign word_end = (state == SHIFT) && (bit_cnt == BIT_LAST);

    // A new word may only slip in on the last bit of a non-final word,
    // so bit_valid never drops inside a frame.
    assign s_ready     = (state == IDLE) || (word_end && !last_flag);
    assign bit_out     = (state == SHIFT) ? shreg[DATA_W-1] : 1'b0;
    assign bit_valid   = (state != IDLE);
    assign tail_active = (state == TAIL);
    assign frame_done  = (state == TAIL) && (tail_cnt == TAIL_LAST);
    assign underrun    = underrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            tail_cnt   <= '0;
            last_flag  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s_valid) begin
                        shreg     <= s_data;
                        last_flag <= s_last;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!word_end) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + BW'(1);
                    end else if (last_flag) begin
                        tail_cnt <= '0;
                        state    <= TAIL;
                    end else if (s_valid) begin
                        shreg     <= s_data;
                        last_flag <= s_last;
                        bit_cnt   <= '0;
                    end else begin
                        // Source starved mid-frame: flush and close the
                        // frame rather than let bit_valid drop.
                        underrun_q <= 1'b1;
                        tail_cnt   <= '0;
                        state      <= TAIL;
                    end
                end
                TAIL: begin
                    if (tail_cnt == TAIL_LAST) begin
                        state <= IDLE;
                    end else begin
                        tail_cnt <= tail_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_enc_framer.sv
// Self-checking bench for conv_enc_framer: queue-based reference model,
// directed frames with literal bit patterns, then randomized traffic.
module tb_conv_enc_framer;
    import conv_enc_pkg::*;

    localparam int DW = 8;
    localparam int TL = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          bit_out;
    logic          bit_valid;
    logic          tail_active;
    logic          frame_done;
    logic          underrun;

    conv_enc_framer #(.DATA_W(DW), .TAIL_LEN(TL)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .tail_active(tail_active),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: queue of bits still to appear on the serial side.
    typedef struct packed {
        logic b;
        logic tl;
        logic dn;
        logic ur;
        logic wend;
    } ent_t;

    ent_t q[$];

    logic [63:0] cb, ct, cd, cu, cr;
    int          nc;

    task automatic cap_clr();
        cb = '0; ct = '0; cd = '0; cu = '0; cr = '0; nc = 0;
    endtask

    task automatic push_tail(input logic und);
        ent_t e;
        for (int j = 0; j < TL; j++) begin
            e = '0;
            e.tl = 1'b1;
            e.dn = (j == TL - 1);
            e.ur = und && (j == 0);
            q.push_back(e);
        end
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d,
                       input logic l, output logic acc);
        ent_t e;
        logic er;
        logic ev;
        @(posedge clk);
        #1;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        ev = (q.size() != 0);
        e  = ev ? q[0] : '0;
        er = !ev || e.wend;
        chk("s_ready", 64'(s_ready), 64'(er));
        chk("bit_out", 64'(bit_out), 64'(e.b));
        chk("bit_valid", 64'(bit_valid), 64'(ev));
        chk("tail_active", 64'(tail_active), 64'(e.tl));
        chk("frame_done", 64'(frame_done), 64'(e.dn));
        chk("underrun", 64'(underrun), 64'(e.ur));
        if (bit_valid) begin
            cb = {cb[62:0], bit_out};
            ct = {ct[62:0], tail_active};
            cd = {cd[62:0], frame_done};
            cu = {cu[62:0], underrun};
            cr = {cr[62:0], s_ready};
            nc++;
        end
        acc = v && er;
        if (ev) begin
            void'(q.pop_front());
            if (e.wend && !acc) push_tail(1'b1);
        end
        if (acc) begin
            for (int i = DW - 1; i >= 0; i--) begin
                e = '0;
                e.b = d[i];
                e.wend = (i == 0) && !l;
                q.push_back(e);
            end
            if (l) push_tail(1'b0);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            cyc(1'b1, d, l, acc);
            n++;
        end
        if (!acc) begin
            errs++;
            checks++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, acc);
    endtask

    function automatic logic [63:0] encode(input logic [63:0] bits,
                                           input int n,
                                           output logic [K-1:0] r);
        logic [63:0] o;
        o = '0;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            r = {bits[i], r[K-1:1]};
            o = {o[61:0], ^(r & POLY_1), ^(r & POLY_2)};
        end
        return o;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        logic          pend;
        logic [DW-1:0] pd;
        logic          pl;
        logic [K-1:0]  er;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bit_valid", 64'(bit_valid), 64'(0));
        chk("rst_bit_out", 64'(bit_out), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(1));
        chk("rst_done_und", 64'({frame_done, underrun, tail_active}), 64'(0));
        rst = 1'b0;

        // single word, last
        cap_clr();
        send(8'hA5, 1'b1);
        idle(14);
        chk("a5_len", 64'(nc), 64'(12));
        chk("a5_bits", cb[11:0], 64'h0A50);
        chk("a5_tail", ct[11:0], 64'h000F);
        chk("a5_done", cd[11:0], 64'h0001);
        chk("a5_ready", cr[11:0], 64'h0000);

        // back to back
        cap_clr();
        send(8'h3C, 1'b0);
        send(8'hFF, 1'b1);
        idle(14);
        chk("b2b_len", 64'(nc), 64'(20));
        chk("b2b_bits", cb[19:0], 64'h3CFF0);
        chk("b2b_ready", cr[19:0], 64'h01000);

        // underrun
        cap_clr();
        send(8'h81, 1'b0);
        idle(16);
        chk("ur_len", 64'(nc), 64'(12));
        chk("ur_bits", cb[11:0], 64'h0810);
        chk("ur_pulse", cu[11:0], 64'h0008);
        chk("ur_done", cd[11:0], 64'h0001);

        // reset mid-frame on bit 3 of 0xF0
        send(8'hF0, 1'b1);
        idle(2);
        @(posedge clk);
        #1;
        chk("pre_rst_bit", 64'(bit_out), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bit_valid), 64'(0));
        chk("mid_rst_bit", 64'(bit_out), 64'(0));
        chk("mid_rst_tail", 64'(tail_active), 64'(0));
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(s_ready), 64'(1));
        cap_clr();
        send(8'h01, 1'b1);
        idle(14);
        chk("post_rst_len", 64'(nc), 64'(12));
        chk("post_rst_bits", cb[11:0], 64'h0010);

        // encoder impulse response through the framer
        cap_clr();
        send(8'h80, 1'b1);
        idle(14);
        chk("enc_bits", cb[11:0], 64'h0800);
        chk("enc_pairs", encode(cb, nc, er), 64'hDAC000);
        chk("enc_state", 64'(er), 64'(0));

        // randomized traffic
        pend = 1'b0;
        pd = '0;
        pl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend = 1'b1;
                pd = DW'($urandom);
                pl = ($urandom_range(0, 3) == 0);
            end
            cyc(pend, pd, pl, acc);
            if (acc) pend = 1'b0;
        end
        idle(20);
        chk("drain", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
